key_move_decoder: RTL and testbench

- Upstream stage of the maze game controller. Turns PS/2 set-2 scan bytes into the 3-bit move code the controller samples in READ_KEY.
- Parses make, break and extended prefixes, and tracks which of the four directions are held.
- Latches the most recent press so a tap between two controller reads is not lost.
- Owns the key register that the controller drives through en_key/s_key.

---
 rtl/maze_pkg.sv | 64 ++++++
 rtl/key_move_decoder_if.sv | 21 ++
 rtl/ps2_prefix_parser.sv | 87 ++++++++
 rtl/key_move_decoder.sv | 80 ++++++++
 tb/tb_key_move_decoder.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/maze_pkg.sv
// Shared types and constants for the maze game front end:
// move codes, PS/2 set-2 scan codes and parser states.
package maze_pkg;

  typedef enum logic [2:0] {
    MOVE_NONE  = 3'd0,
    MOVE_LEFT  = 3'd1,
    MOVE_RIGHT = 3'd2,
    MOVE_UP    = 3'd3,
    MOVE_DOWN  = 3'd4
  } move_t;

  typedef enum logic [1:0] {
    P_IDLE,
    P_E0,
    P_F0,
    P_E0F0
  } pstate_t;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;

  function automatic move_t dir_of(
    input logic [7:0] code,
    input logic       ext,
    input logic       wasd
  );
    dir_of = MOVE_NONE;
    if (ext) begin
      case (code)
        SC_LEFT:  dir_of = MOVE_LEFT;
        SC_RIGHT: dir_of = MOVE_RIGHT;
        SC_UP:    dir_of = MOVE_UP;
        SC_DOWN:  dir_of = MOVE_DOWN;
        default:  dir_of = MOVE_NONE;
      endcase
    end else if (wasd) begin
      case (code)
        SC_A:    dir_of = MOVE_LEFT;
        SC_D:    dir_of = MOVE_RIGHT;
        SC_W:    dir_of = MOVE_UP;
        SC_S:    dir_of = MOVE_DOWN;
        default: dir_of = MOVE_NONE;
      endcase
    end
  endfunction

  function automatic move_t held_pick(input logic [3:0] h);
    if (h[0])      held_pick = MOVE_LEFT;
    else if (h[1]) held_pick = MOVE_RIGHT;
    else if (h[2]) held_pick = MOVE_UP;
    else if (h[3]) held_pick = MOVE_DOWN;
    else           held_pick = MOVE_NONE;
  endfunction

endpackage

// File: rtl/key_move_decoder_if.sv
// Scan-byte input, controller key-register controls
// and decoded move outputs of the key decoder.
interface key_move_decoder_if;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       en_key;
  logic       s_key;
  logic [2:0] move;
  logic [3:0] key_held;
  logic       parse_abort;

  modport master (
    output scan_code, scan_valid, en_key, s_key,
    input  move, key_held, parse_abort
  );

  modport slave (
    input  scan_code, scan_valid, en_key, s_key,
    output move, key_held, parse_abort
  );
endinterface

// File: rtl/ps2_prefix_parser.sv
// Tracks E0/F0 prefixes of PS/2 set-2 bytes and emits one
// strobe per completed code; abandons stalled prefixes.
module ps2_prefix_parser
  import maze_pkg::*;
#(
  parameter logic [15:0] PREFIX_TIMEOUT = 16'd50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic       code_strobe,
  output logic [7:0] code,
  output logic       extended,
  output logic       is_break,
  output logic       parse_abort
);

  pstate_t     state;
  logic [15:0] cnt;

  // Prefix state, stall counter and registered abort pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= P_IDLE;
      cnt         <= '0;
      parse_abort <= 1'b0;
    end else begin
      parse_abort <= 1'b0;
      if (scan_valid) begin
        cnt <= '0;
        case (state)
          P_IDLE: begin
            if (scan_code == SC_E0)      state <= P_E0;
            else if (scan_code == SC_F0) state <= P_F0;
            else                         state <= P_IDLE;
          end
          P_E0: begin
            if (scan_code == SC_F0) state <= P_E0F0;
            else                    state <= P_IDLE;
          end
          default: state <= P_IDLE;
        endcase
      end else if (state != P_IDLE) begin
        if (cnt == PREFIX_TIMEOUT - 16'd1) begin
          state       <= P_IDLE;
          cnt         <= '0;
          parse_abort <= 1'b1;
        end else begin
          cnt <= cnt + 16'd1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  // A byte that completes a code is reported in its own cycle
  always_comb begin
    code_strobe = 1'b0;
    extended    = 1'b0;
    is_break    = 1'b0;
    code        = scan_code;
    if (scan_valid) begin
      case (state)
        P_IDLE: begin
          code_strobe = (scan_code != SC_E0) &&
                        (scan_code != SC_F0);
        end
        P_E0: begin
          code_strobe = (scan_code != SC_F0);
          extended    = 1'b1;
        end
        P_F0: begin
          code_strobe = 1'b1;
          is_break    = 1'b1;
        end
        default: begin
          code_strobe = 1'b1;
          extended    = 1'b1;
          is_break    = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_move_decoder.sv
// PS/2 direction keys to a registered 3-bit move code,
// with held-key tracking and a latched last press.
module key_move_decoder
  import maze_pkg::*;
#(
  parameter logic [15:0] PREFIX_TIMEOUT = 16'd50000,
  parameter bit          WASD_EN        = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  key_move_decoder_if.slave bus
);

  logic       code_strobe;
  logic [7:0] code;
  logic       extended;
  logic       is_break;
  logic       parse_abort;

  ps2_prefix_parser #(
    .PREFIX_TIMEOUT(PREFIX_TIMEOUT)
  ) u_parser (
    .clk        (clk),
    .reset      (reset),
    .scan_code  (bus.scan_code),
    .scan_valid (bus.scan_valid),
    .code_strobe(code_strobe),
    .code       (code),
    .extended   (extended),
    .is_break   (is_break),
    .parse_abort(parse_abort)
  );

  move_t      move_q;
  move_t      pending;
  move_t      pend_n;
  move_t      dir;
  move_t      resolved;
  logic [3:0] key_held;
  logic [3:0] held_n;
  logic [1:0] idx;

  assign dir = dir_of(code, extended, WASD_EN);
  assign idx = dir[1:0] - 2'd1;
  assign resolved = (pending != MOVE_NONE) ?
                    pending : held_pick(key_held);

  // Key-register side effects first, then the new key event
  always_comb begin
    held_n = key_held;
    pend_n = pending;
    if (bus.en_key) begin
      pend_n = MOVE_NONE;
      if (!bus.s_key) held_n = '0;
    end
    if (code_strobe && dir != MOVE_NONE) begin
      held_n[idx] = !is_break;
      if (!is_break) pend_n = dir;
    end
  end

  // Move, held mask and pending press registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      move_q   <= MOVE_NONE;
      pending  <= MOVE_NONE;
      key_held <= '0;
    end else begin
      key_held <= held_n;
      pending  <= pend_n;
      if (bus.en_key)
        move_q <= bus.s_key ? resolved : MOVE_NONE;
    end
  end

  assign bus.move        = move_q;
  assign bus.key_held    = key_held;
  assign bus.parse_abort = parse_abort;

endmodule

// File: tb/tb_key_move_decoder.sv
// Directed and random scan-byte traffic against a
// key-event level model of the move decoder.
module tb_key_move_decoder;
  import maze_pkg::*;

  localparam logic [15:0] TO = 16'd20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  key_move_decoder_if bus();

  key_move_decoder #(
    .PREFIX_TIMEOUT(TO),
    .WASD_EN       (1'b1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  bit mheld[4];
  int mpend  = 0;
  int mmove  = 0;
  bit mext   = 0;
  bit mbrk   = 0;
  int midle  = 0;
  bit mabort = 0;

  int kc[11] = '{'h6B, 'h74, 'h75, 'h72, 'h1C, 'h23,
                 'h1D, 'h1B, 'h29, 'h5A, 'h70};
  bit ke[11] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int dir_lookup(int c, bit ext);
    int arrow[4] = '{'h6B, 'h74, 'h75, 'h72};
    int wasd[4]  = '{'h1C, 'h23, 'h1D, 'h1B};
    for (int i = 0; i < 4; i++) begin
      if (ext && c == arrow[i]) return i + 1;
      if (!ext && c == wasd[i]) return i + 1;
    end
    return 0;
  endfunction

  function automatic int m_resolve();
    if (mpend != 0) return mpend;
    for (int i = 0; i < 4; i++)
      if (mheld[i]) return i + 1;
    return 0;
  endfunction

  function automatic int m_mask();
    int m = 0;
    for (int i = 0; i < 4; i++)
      if (mheld[i]) m += (1 << i);
    return m;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) mheld[i] = 0;
    mpend = 0; mmove = 0; mext = 0; mbrk = 0;
    midle = 0; mabort = 0;
  endtask

  task automatic tick(input int b, input bit v,
                      input bit en, input bit s);
    int ev = 0;
    bit brk = 0;
    int res;
    bus.scan_code  = b[7:0];
    bus.scan_valid = v;
    bus.en_key     = en;
    bus.s_key      = s;
    mabort = 0;
    res = m_resolve();
    if (v) begin
      midle = 0;
      if (mbrk) begin
        ev = dir_lookup(b, mext); brk = 1;
        mext = 0; mbrk = 0;
      end else if (b == 'hF0) begin
        mbrk = 1;
      end else if (b == 'hE0 && !mext) begin
        mext = 1;
      end else begin
        ev = dir_lookup(b, mext); mext = 0;
      end
    end else if (mext || mbrk) begin
      midle++;
      if (midle == int'(TO)) begin
        mabort = 1; mext = 0; mbrk = 0; midle = 0;
      end
    end
    if (en) begin
      mmove = s ? res : 0;
      mpend = 0;
      if (!s) for (int i = 0; i < 4; i++) mheld[i] = 0;
    end
    if (ev != 0) begin
      mheld[ev-1] = !brk;
      if (!brk) mpend = ev;
    end
    @(posedge clk);
    #1;
    chk("move", bus.move, mmove);
    chk("held", bus.key_held, m_mask());
    chk("abort", bus.parse_abort, mabort);
    @(negedge clk);
  endtask

  task automatic send(input int b);
    tick(b, 1, 0, 0);
  endtask

  task automatic load();
    tick(0, 0, 1, 1);
  endtask

  task automatic clr();
    tick(0, 0, 1, 0);
  endtask

  task automatic rgap();
    bit en;
    en = ($urandom_range(0, 5) == 0);
    tick(0, 0, en, 1'($urandom_range(0, 1)));
  endtask

  task automatic rbyte(input int b);
    bit en;
    en = ($urandom_range(0, 5) == 0);
    tick(b, 1, en, 1'($urandom_range(0, 1)));
    repeat ($urandom_range(0, 2)) rgap();
  endtask

  int n;
  int k;

  initial begin
    reset          = 1'b1;
    bus.scan_code  = '0;
    bus.scan_valid = 1'b0;
    bus.en_key     = 1'b0;
    bus.s_key      = 1'b0;
    m_reset();
    #12;
    chk("rst_move", bus.move, 0);
    chk("rst_held", bus.key_held, 0);
    chk("rst_abort", bus.parse_abort, 0);
    @(negedge clk);
    reset = 1'b0;

    send('hE0); send('h75); load();
    chk("press_move", bus.move, 3);
    chk("press_held", bus.key_held, 4'b0100);

    clr();
    send('hE0); send('h6B);
    send('hE0); send('hF0); send('h6B);
    load();
    chk("tap_move", bus.move, 1);
    chk("tap_held", bus.key_held, 0);
    load();
    chk("tap_move2", bus.move, 0);

    send('hE0); send('h72);
    send('hE0); send('h74);
    load();
    chk("recent_move", bus.move, 2);
    load();
    chk("prio_move", bus.move, 2);
    send('hE0); send('hF0); send('h74);
    load();
    chk("release_move", bus.move, 4);

    send('h1C); clr();
    chk("clr_move", bus.move, 0);
    chk("clr_held", bus.key_held, 0);
    load();
    chk("clr_load", bus.move, 0);

    send('hE0);
    n = 0;
    repeat (int'(TO) + 5) begin
      tick(0, 0, 0, 0);
      if (bus.parse_abort === 1'b1) n++;
    end
    chk("abort_pulses", n, 1);
    send('h74);
    chk("post_abort_held", bus.key_held, 0);

    send('h1D);
    send('hE0);
    tick('h6B, 1, 1, 1);
    chk("race_move", bus.move, 3);
    load();
    chk("race_next", bus.move, 1);

    send('hE0);
    #2 reset = 1'b1;
    #1;
    chk("arst_move", bus.move, 0);
    chk("arst_held", bus.key_held, 0);
    chk("arst_abort", bus.parse_abort, 0);
    m_reset();
    @(negedge clk);
    reset = 1'b0;
    send('h6B);
    chk("arst_idle_held", bus.key_held, 0);
    load();
    chk("arst_idle_move", bus.move, 0);

    repeat (400) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: begin
          k = $urandom_range(0, 10);
          if (ke[k]) rbyte('hE0);
          if ($urandom_range(0, 1) == 1) rbyte('hF0);
          rbyte(kc[k]);
        end
        6: load();
        7: clr();
        default: repeat ($urandom_range(1, 3)) rgap();
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
